// File: rtl/computer_system_multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : computer_system_multi_timer_pkg
// Description : Register offsets and field positions that the multi-channel
//               timer and its channel sub-module share.
// Revision    : 1.0 - initial release
// ============================================================================
package computer_system_multi_timer_pkg;

    // Word offsets of the registers inside one channel's window
    localparam logic [1:0] c_reg_status   = 2'd0;
    localparam logic [1:0] c_reg_control  = 2'd1;
    localparam logic [1:0] c_reg_period   = 2'd2;
    localparam logic [1:0] c_reg_snapshot = 2'd3;

    // CONTROL bit positions; START and STOP are write-only pulses
    localparam int c_ctrl_ito   = 0;
    localparam int c_ctrl_cont  = 1;
    localparam int c_ctrl_start = 2;
    localparam int c_ctrl_stop  = 3;

    // CONTROL prescaler field range
    localparam int c_presc_lsb = 8;
    localparam int c_presc_msb = 15;

    // STATUS bit positions
    localparam int c_stat_to  = 0;
    localparam int c_stat_run = 1;

endpackage : computer_system_multi_timer_pkg
`default_nettype wire

// File: rtl/computer_system_timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : computer_system_timer_channel
// Description : One timer channel: STATUS/CONTROL/PERIOD/SNAPSHOT registers,
//               8-bit prescaler and down-counter with reload on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module computer_system_timer_channel
    import computer_system_multi_timer_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int PERIOD_RST = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wr,
    input  logic [1:0]  i_reg,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_snap;
    logic [7:0]       r_presc_cnt;
    logic [7:0]       r_presc;
    logic             r_run;
    logic             r_to;
    logic             r_ito;
    logic             r_cont;

    logic w_tick;
    logic w_expire;
    logic w_wr_status;
    logic w_wr_control;
    logic w_wr_period;
    logic w_wr_snapshot;
    logic w_unused_wdata;

    // Tick and expiry decode plus per-register write strobes
    always_comb begin
        w_tick        = r_run && (r_presc_cnt == r_presc);
        w_expire      = w_tick && (r_cnt == '0);
        w_wr_status   = i_wr && (i_reg == c_reg_status);
        w_wr_control  = i_wr && (i_reg == c_reg_control);
        w_wr_period   = i_wr && (i_reg == c_reg_period);
        w_wr_snapshot = i_wr && (i_reg == c_reg_snapshot);
    end

    // Not every write-data bit lands in a register
    assign w_unused_wdata = &{1'b0, i_wdata};

    // Channel state: prescaler, counter, run/timeout flags and config registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= CNT_W'(PERIOD_RST);
            r_period    <= CNT_W'(PERIOD_RST);
            r_snap      <= '0;
            r_presc_cnt <= '0;
            r_presc     <= '0;
            r_run       <= 1'b0;
            r_to        <= 1'b0;
            r_ito       <= 1'b0;
            r_cont      <= 1'b0;
        end else begin
            // Prescaler only advances while running and restarts after each tick
            if (!r_run || w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + 8'd1;
            end

            // Counting; a PERIOD write overrides whatever the tick would do
            if (w_wr_period) begin
                r_period <= i_wdata[CNT_W-1:0];
                r_cnt    <= i_wdata[CNT_W-1:0];
                r_run    <= 1'b0;
            end else begin
                if (w_tick) begin
                    if (w_expire) begin
                        r_cnt <= r_period;
                        if (!r_cont) begin
                            r_run <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // START beats STOP when both are written together
                if (w_wr_control) begin
                    if (i_wdata[c_ctrl_start]) begin
                        r_run <= 1'b1;
                    end else if (i_wdata[c_ctrl_stop]) begin
                        r_run <= 1'b0;
                    end
                end
            end

            // A timeout in the same cycle as a STATUS write keeps TO set
            if (w_expire) begin
                r_to <= 1'b1;
            end else if (w_wr_status) begin
                r_to <= 1'b0;
            end

            if (w_wr_control) begin
                r_ito   <= i_wdata[c_ctrl_ito];
                r_cont  <= i_wdata[c_ctrl_cont];
                r_presc <= i_wdata[c_presc_msb:c_presc_lsb];
            end

            if (w_wr_snapshot) begin
                r_snap <= r_cnt;
            end
        end
    end

    // Register read mux for this channel
    always_comb begin
        o_rdata = '0;
        case (i_reg)
            c_reg_status: begin
                o_rdata[c_stat_to]  = r_to;
                o_rdata[c_stat_run] = r_run;
            end
            c_reg_control: begin
                o_rdata[c_ctrl_ito]                = r_ito;
                o_rdata[c_ctrl_cont]               = r_cont;
                o_rdata[c_presc_msb:c_presc_lsb]   = r_presc;
            end
            c_reg_period:   o_rdata = 32'(r_period);
            default:        o_rdata = 32'(r_snap);
        endcase
    end

    assign o_irq = r_to & r_ito;

endmodule : computer_system_timer_channel
`default_nettype wire

// File: rtl/computer_system_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : computer_system_multi_timer
// Description : NUM_CH independent timer channels behind a word-addressed
//               slave port with registered read data and combined interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module computer_system_multi_timer
    import computer_system_multi_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PERIOD_RST = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(NUM_CH)+1:0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        irq,
    output logic [NUM_CH-1:0]           irq_vec
);

    localparam int AW = $clog2(NUM_CH) + 2;

    logic [AW-1:0] w_ch;
    logic [1:0]    w_reg;
    logic          w_wr;
    logic [31:0]   w_rdata;
    logic [31:0]   w_ch_rdata [NUM_CH];

    // Upper address bits pick the channel, low two bits the register
    assign w_ch  = address >> 2;
    assign w_reg = address[1:0];
    assign w_wr  = chipselect && !write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        computer_system_timer_channel #(
            .CNT_W      (CNT_W),
            .PERIOD_RST (PERIOD_RST)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .i_wr    (w_wr && (w_ch == AW'(g))),
            .i_reg   (w_reg),
            .i_wdata (writedata),
            .o_rdata (w_ch_rdata[g]),
            .o_irq   (irq_vec[g])
        );
    end

    // Channel select for reads; unpopulated channel slots read as zero
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == AW'(i)) begin
                w_rdata = w_ch_rdata[i];
            end
        end
    end

    // Read data is re-registered every cycle from the current address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

    assign irq = |irq_vec;

endmodule : computer_system_multi_timer
`default_nettype wire

// File: tb/tb_computer_system_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_computer_system_multi_timer
// Description : Self-checking bench: vector table, hand-built corner
//               sequences and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_computer_system_multi_timer;

    localparam int NCH  = 4;
    localparam int CW   = 16;
    localparam int MASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;

    int n_vec = 0;
    int n_err = 0;

    computer_system_multi_timer #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .PERIOD_RST (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (per-channel timer behaviour) --------
    int m_period [NCH];
    int m_cnt    [NCH];
    int m_pc     [NCH];
    int m_presc  [NCH];
    int m_snap   [NCH];
    bit m_run    [NCH];
    bit m_to     [NCH];
    bit m_ito    [NCH];
    bit m_cont   [NCH];
    int m_rd;

    function automatic int model_read(int ch, int rg);
        case (rg)
            0:       return (int'(m_run[ch]) << 1) | int'(m_to[ch]);
            1:       return (m_presc[ch] << 8) | (int'(m_cont[ch]) << 1) | int'(m_ito[ch]);
            2:       return m_period[ch];
            default: return m_snap[ch];
        endcase
    endfunction

    function automatic logic [3:0] model_irqv();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_period[c] = 1; m_cnt[c] = 1; m_pc[c] = 0; m_presc[c] = 0; m_snap[c] = 0;
            m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
        end
        m_rd = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int ch, rg, wd, old_cnt;
        bit wr, own, tick, expire;
        ch = int'(address) >> 2;
        rg = int'(address) & 3;
        wd = int'(writedata);
        wr = chipselect && !write_n;
        m_rd = model_read(ch, rg);
        for (int c = 0; c < NCH; c++) begin
            own     = wr && (c == ch);
            tick    = m_run[c] && (m_pc[c] == m_presc[c]);
            expire  = tick && (m_cnt[c] == 0);
            old_cnt = m_cnt[c];
            m_pc[c] = (m_run[c] && !tick) ? (m_pc[c] + 1) % 256 : 0;
            if (tick) m_cnt[c] = expire ? m_period[c] : m_cnt[c] - 1;
            if (expire && !m_cont[c]) m_run[c] = 0;
            if (own && rg == 0) m_to[c] = 0;
            if (expire) m_to[c] = 1;
            if (own && rg == 1) begin
                m_ito[c]   = writedata[0];
                m_cont[c]  = writedata[1];
                m_presc[c] = (wd >> 8) & 255;
                if (writedata[2]) m_run[c] = 1;
                else if (writedata[3]) m_run[c] = 0;
            end
            if (own && rg == 2) begin
                m_period[c] = wd & MASK;
                m_cnt[c]    = m_period[c];
                m_run[c]    = 0;
            end
            if (own && rg == 3) m_snap[c] = old_cnt;
        end
    endtask

    // ---------------- bus helpers (inputs change only while clk is low) ----
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(int a, logic [31:0] d);
        address = 4'(a); chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        idle_bus();
    endtask

    task automatic bus_read(int a);
        address = 4'(a); chipselect = 1'b1; write_n = 1'b1;
        tick();
        idle_bus();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_bus();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_irq(int ch, int limit, output int cycles);
        cycles = 0;
        while (!irq_vec[ch] && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    // ---------------- vector table ----------------------------------------
    typedef struct {
        int          addr;
        bit          wr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_irqv;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int cyc;
        logic [31:0] rnd;

        tbl[0]  = '{0,  0, 32'h0,         32'h0,    4'b0000};
        tbl[1]  = '{2,  0, 32'h0,         32'h1,    4'b0000};
        tbl[2]  = '{13, 0, 32'h0,         32'h0,    4'b0000};
        tbl[3]  = '{5,  1, 32'h0000_0A03, 32'h0,    4'b0000};
        tbl[4]  = '{5,  0, 32'h0,         32'h0A03, 4'b0000};
        tbl[5]  = '{10, 1, 32'hFFFF_1234, 32'h1,    4'b0000};
        tbl[6]  = '{10, 0, 32'h0,         32'h1234, 4'b0000};
        tbl[7]  = '{11, 1, 32'h0,         32'h0,    4'b0000};
        tbl[8]  = '{11, 0, 32'h0,         32'h1234, 4'b0000};
        tbl[9]  = '{4,  0, 32'h0,         32'h0,    4'b0000};
        tbl[10] = '{5,  1, 32'hC,         32'h0A03, 4'b0000};
        tbl[11] = '{4,  0, 32'h0,         32'h2,    4'b0000};
        tbl[12] = '{5,  1, 32'h8,         32'h0,    4'b0000};
        tbl[13] = '{4,  0, 32'h0,         32'h1,    4'b0000};
        tbl[14] = '{7,  0, 32'h0,         32'h0,    4'b0000};
        tbl[15] = '{4,  1, 32'h0,         32'h1,    4'b0000};
        tbl[16] = '{4,  0, 32'h0,         32'h0,    4'b0000};
        tbl[17] = '{5,  1, 32'h5,         32'h0,    4'b0000};
        tbl[18] = '{0,  0, 32'h0,         32'h0,    4'b0000};
        tbl[19] = '{0,  0, 32'h0,         32'h0,    4'b0010};
        tbl[20] = '{4,  0, 32'h0,         32'h1,    4'b0010};

        // Reset state
        do_reset();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_irq_vec", {28'b0, irq_vec}, 32'h0);

        // Table-driven register access
        for (int i = 0; i < 21; i++) begin
            address    = 4'(tbl[i].addr);
            chipselect = 1'b1;
            write_n    = !tbl[i].wr;
            writedata  = tbl[i].wd;
            tick();
            chk($sformatf("tbl%0d_readdata", i), readdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq_vec", i), {28'b0, irq_vec}, {28'b0, tbl[i].exp_irqv});
        end
        idle_bus();

        // Continuous channel 0, period 10 cycles
        do_reset();
        bus_write(2, 32'd9);
        bus_write(1, 32'h7);
        wait_irq(0, 40, cyc);
        chk("cont_first_timeout_cycles", 32'(cyc), 32'd10);
        chk("cont_irq_vec", {28'b0, irq_vec}, 32'h1);
        chk("cont_irq", {31'b0, irq}, 32'h1);
        bus_write(0, 32'h0);
        chk("status_clear_irq", {31'b0, irq}, 32'h0);
        wait_irq(0, 40, cyc);
        chk("cont_second_timeout_cycles", 32'(cyc), 32'd9);

        // STATUS write landing on the timeout edge
        bus_write(0, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        chk("pre_collision_irq", {31'b0, irq}, 32'h0);
        bus_write(0, 32'h0);
        chk("collision_irq", {31'b0, irq}, 32'h1);
        bus_read(0);
        chk("collision_status", readdata, 32'h3);

        // One-shot with prescaler on channel 2
        do_reset();
        bus_write(10, 32'd3);
        bus_write(9, 32'h0405);
        wait_irq(2, 60, cyc);
        chk("oneshot_cycles", 32'(cyc), 32'd20);
        bus_read(8);
        chk("oneshot_status", readdata, 32'h1);
        bus_write(11, 32'h0);
        bus_read(11);
        chk("oneshot_counter", readdata, 32'h3);

        // PERIOD write on a running channel
        do_reset();
        bus_write(5, 32'h7);
        for (int i = 0; i < 3; i++) tick();
        bus_write(6, 32'd100);
        bus_read(4);
        chk("period_write_run", readdata & 32'h2, 32'h0);
        bus_write(7, 32'h0);
        bus_read(7);
        chk("period_write_snapshot", readdata, 32'd100);

        // START+STOP together, then STOP freezes the counter
        do_reset();
        bus_write(14, 32'd50);
        bus_write(13, 32'hC);
        bus_read(12);
        chk("start_stop_run", readdata, 32'h2);
        bus_write(13, 32'h8);
        bus_write(15, 32'h0);
        bus_read(15);
        chk("stop_snapshot", readdata, 32'd48);
        for (int i = 0; i < 5; i++) tick();
        bus_write(15, 32'h0);
        bus_read(15);
        chk("stop_snapshot_frozen", readdata, 32'd48);
        bus_read(12);
        chk("stop_status", readdata, 32'h0);

        // Asynchronous reset in the middle of a count
        do_reset();
        bus_write(2, 32'd9);
        bus_write(1, 32'h7);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_readdata", readdata, 32'h2);
        reset_n = 1'b0;
        #2;
        chk("async_reset_readdata", readdata, 32'h0);
        chk("async_reset_irq", {31'b0, irq}, 32'h0);
        chk("async_reset_irq_vec", {28'b0, irq_vec}, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2);
        chk("post_reset_period", readdata, 32'h1);
        wait_irq(0, 30, cyc);
        chk("post_reset_no_irq", 32'(cyc), 32'd30);
        bus_write(1, 32'h5);
        wait_irq(0, 30, cyc);
        chk("rearm_timeout_cycles", 32'(cyc), 32'd2);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            address    = 4'($urandom_range(0, 15));
            chipselect = ($urandom_range(0, 9) != 0);
            write_n    = ($urandom_range(0, 9) >= 3);
            rnd        = $urandom;
            case (address[1:0])
                2'd1:    writedata = (rnd & 32'hFFFF_00FF) | (32'($urandom_range(0, 3)) << 8);
                2'd2:    writedata = (rnd & 32'hFFFF_0000) | 32'($urandom_range(0, 15));
                default: writedata = rnd;
            endcase
            tick();
            chk("rand_readdata", readdata, 32'(m_rd));
            chk("rand_irq_vec", {28'b0, irq_vec}, {28'b0, model_irqv()});
            chk("rand_irq", {31'b0, irq}, {31'b0, |model_irqv()});
        end
        idle_bus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_computer_system_multi_timer
`default_nettype wire
